// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the LEGv8 subset (ADD, SUB, AND, ORR, LDUR, STUR, CBZ).
// Steers the datapath per phase and handshakes with data memory, with a timeout abort.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             dmem_ready,
  output logic             ir_en,
  output logic             pc_en,
  output logic             pc_src,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_LD  = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_ABORT  = 4'd9
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TW-1:0]    r_tmo;
  logic [TW-1:0]    w_tmo_next;
  logic             r_store;
  logic             w_store_next;
  logic [CNT_W-1:0] r_retired;

  logic       w_ir_en;
  logic       w_pc_en;
  logic       w_pc_src;
  logic       w_reg2loc;
  logic       w_alu_src;
  logic [1:0] w_alu_op;
  logic       w_reg_write;
  logic       w_mem_to_reg;
  logic       w_dmem_req;
  logic       w_dmem_we;
  logic       w_illegal;
  logic       w_mem_err;

  // State, timeout counter, load/store flag and retired counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_tmo     <= '0;
      r_store   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_tmo   <= w_tmo_next;
      r_store <= w_store_next;
      if (w_pc_en) begin
        r_retired <= r_retired + CNT_W'(1);
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next       = r_state;
    w_tmo_next   = r_tmo;
    w_store_next = r_store;
    w_ir_en      = 1'b0;
    w_pc_en      = 1'b0;
    w_pc_src     = 1'b0;
    w_reg2loc    = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = 2'b00;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_illegal    = 1'b0;
    w_mem_err    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_en = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        casez (opcode)
          11'b10001011000, 11'b11001011000,
          11'b10001010000, 11'b10101010000: w_next = S_EXEC_R;
          11'b11111000010: begin
            w_store_next = 1'b0;
            w_next       = S_ADDR;
          end
          11'b11111000000: begin
            w_store_next = 1'b1;
            w_reg2loc    = 1'b1;
            w_next       = S_ADDR;
          end
          11'b10110100???: begin
            w_reg2loc = 1'b1;
            w_next    = S_BRANCH;
          end
          default: begin
            w_illegal = 1'b1;
            w_next    = S_ABORT;
          end
        endcase
      end
      S_EXEC_R: begin
        w_alu_op = 2'b10;
        w_next   = S_WB_R;
      end
      S_WB_R: begin
        w_reg_write = 1'b1;
        w_pc_en     = 1'b1;
        w_next      = S_FETCH;
      end
      S_ADDR: begin
        w_alu_src  = 1'b1;
        w_reg2loc  = r_store;
        w_tmo_next = '0;
        w_next     = r_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_state == S_MEM_WR);
        w_alu_src  = 1'b1;
        if (dmem_ready) begin
          if (r_state == S_MEM_WR) begin
            w_pc_en = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next  = S_WB_LD;
          end
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_mem_err = 1'b1;
          w_next    = S_ABORT;
        end else begin
          w_tmo_next = r_tmo + TW'(1);
        end
      end
      S_WB_LD: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_pc_en      = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_op  = 2'b01;
        w_reg2loc = 1'b1;
        w_pc_en   = 1'b1;
        w_pc_src  = zero;
        w_next    = S_FETCH;
      end
      S_ABORT: begin
        w_pc_en = 1'b1;
        w_next  = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces every control output low combinationally, so a pending request drops at once
  assign ir_en      = w_ir_en      & ~reset;
  assign pc_en      = w_pc_en      & ~reset;
  assign pc_src     = w_pc_src     & ~reset;
  assign reg2loc    = w_reg2loc    & ~reset;
  assign alu_src    = w_alu_src    & ~reset;
  assign alu_op     = w_alu_op     & {2{~reset}};
  assign reg_write  = w_reg_write  & ~reset;
  assign mem_to_reg = w_mem_to_reg & ~reset;
  assign dmem_req   = w_dmem_req   & ~reset;
  assign dmem_we    = w_dmem_we    & ~reset;
  assign illegal    = w_illegal    & ~reset;
  assign mem_err    = w_mem_err    & ~reset;
  assign retired    = r_retired;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: per-instruction outcomes
// (latency, enables, handshake length, retire count) are predicted from the instruction rules.
module tb_multicycle_ctrl;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;
  localparam int NEVER   = 1000;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;

  logic clk = 1'b0;
  logic reset, zero, dmem_ready;
  logic [10:0] opcode;
  logic ir_en, pc_en, pc_src, reg2loc, alu_src, reg_write, mem_to_reg;
  logic dmem_req, dmem_we, illegal, mem_err;
  logic [1:0] alu_op;
  logic [CNT_W-1:0] retired;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_retired;

  int o_cycles, o_rw, o_m2r, o_req, o_we_bad, o_memerr, o_ill, o_pcen, o_pcsrc, o_moore_bad;
  int seq[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .dmem_ready(dmem_ready),
    .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src),
    .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .illegal(illegal), .mem_err(mem_err), .retired(retired),
    .state_dbg(state_dbg)
  );

  // 0 = R-type, 1 = LDUR, 2 = STUR, 3 = CBZ, 4 = illegal
  function automatic int op_class(input logic [10:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return 0;
    if (op == OP_LDUR) return 1;
    if (op == OP_STUR) return 2;
    if (op[10:3] == 8'b10110100) return 3;
    return 4;
  endfunction

  function automatic logic [12:0] all_outs();
    return {ir_en, pc_en, pc_src, reg2loc, alu_src, alu_op, reg_write, mem_to_reg,
            dmem_req, dmem_we, illegal, mem_err};
  endfunction

  // Runs one instruction from a FETCH negedge; memory answers on wait cycle d (0-based).
  task automatic run_instr(input logic [10:0] op, input logic z, input int d, input logic exp_we);
    int wcnt;
    opcode = op; zero = z; wcnt = 0; seq.delete();
    o_cycles = 0; o_rw = 0; o_m2r = 0; o_req = 0; o_we_bad = 0;
    o_memerr = 0; o_ill = 0; o_pcen = 0; o_pcsrc = 0; o_moore_bad = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0 && state_dbg == 4'd0) break;
      if (state_dbg == 4'd5 || state_dbg == 4'd7) begin
        dmem_ready = (wcnt == d);
        wcnt++;
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      o_cycles++;
      seq.push_back(int'(state_dbg));
      if (reg_write) begin o_rw++; o_m2r = int'(mem_to_reg); end
      if (dmem_req) begin o_req++; if (dmem_we !== exp_we) o_we_bad++; end
      if (mem_err) o_memerr++;
      if (illegal) o_ill++;
      if (pc_en) begin o_pcen++; o_pcsrc = int'(pc_src); end
      if (state_dbg == 4'd0 && ir_en !== 1'b1) o_moore_bad++;
      if (state_dbg == 4'd2 && (alu_op !== 2'b10 || alu_src !== 1'b0)) o_moore_bad++;
      if ((state_dbg == 4'd4 || state_dbg == 4'd5 || state_dbg == 4'd7) &&
          (alu_op !== 2'b00 || alu_src !== 1'b1)) o_moore_bad++;
      if (state_dbg == 4'd8 && (alu_op !== 2'b01 || reg2loc !== 1'b1)) o_moore_bad++;
      @(negedge clk);
    end
  endtask

  task automatic check_instr(input string name, input logic [10:0] op, input logic z, input int d);
    int cls, ec, erw, em2r, ereq, emerr, eill, epcsrc;
    logic hit;
    cls = op_class(op);
    hit = (d < TIMEOUT);
    ec = 3; erw = 0; em2r = 0; ereq = 0; emerr = 0; eill = 0; epcsrc = 0;
    case (cls)
      0: begin ec = 4; erw = 1; end
      1: if (hit) begin ec = 5 + d; erw = 1; em2r = 1; ereq = d + 1; end
         else begin ec = TIMEOUT + 4; ereq = TIMEOUT; emerr = 1; end
      2: if (hit) begin ec = 4 + d; ereq = d + 1; end
         else begin ec = TIMEOUT + 4; ereq = TIMEOUT; emerr = 1; end
      3: epcsrc = int'(z);
      default: eill = 1;
    endcase
    exp_retired = exp_retired + 1;
    run_instr(op, z, d, cls == 2);
    checks++; if (o_cycles !== ec) begin errors++; $display("FAIL %s cycles got %0d exp %0d", name, o_cycles, ec); end
    checks++; if (o_rw !== erw) begin errors++; $display("FAIL %s reg_write_cycles got %0d exp %0d", name, o_rw, erw); end
    checks++; if (o_m2r !== em2r) begin errors++; $display("FAIL %s mem_to_reg got %0d exp %0d", name, o_m2r, em2r); end
    checks++; if (o_req !== ereq) begin errors++; $display("FAIL %s dmem_req_cycles got %0d exp %0d", name, o_req, ereq); end
    checks++; if (o_we_bad !== 0) begin errors++; $display("FAIL %s dmem_we got %0d bad exp 0", name, o_we_bad); end
    checks++; if (o_memerr !== emerr) begin errors++; $display("FAIL %s mem_err got %0d exp %0d", name, o_memerr, emerr); end
    checks++; if (o_ill !== eill) begin errors++; $display("FAIL %s illegal got %0d exp %0d", name, o_ill, eill); end
    checks++; if (o_pcen !== 1) begin errors++; $display("FAIL %s pc_en_cycles got %0d exp 1", name, o_pcen); end
    checks++; if (o_pcsrc !== epcsrc) begin errors++; $display("FAIL %s pc_src got %0d exp %0d", name, o_pcsrc, epcsrc); end
    checks++; if (o_moore_bad !== 0) begin errors++; $display("FAIL %s state_outputs got %0d bad exp 0", name, o_moore_bad); end
    checks++; if (retired !== exp_retired) begin errors++; $display("FAIL %s retired got %0d exp %0d", name, retired, exp_retired); end
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = OP_ADD; zero = 1'b0; dmem_ready = 1'b1;
    exp_retired = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (all_outs() !== 13'd0) begin errors++; $display("FAIL reset_outs got %b exp 0", all_outs()); end
    checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    checks++; if (retired !== '0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retired); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    int exp_seq[$];
    exp_seq = '{0, 1, 2, 3};
    check_instr("add", OP_ADD, 1'b0, 0);
    checks++; if (seq !== exp_seq) begin errors++; $display("FAIL add_seq got %p exp %p", seq, exp_seq); end
  endtask

  task automatic test_ldur_delay();
    check_instr("ldur_delay3", OP_LDUR, 1'b0, 3);
  endtask

  task automatic test_stur_timeout();
    check_instr("stur_timeout", OP_STUR, 1'b0, NEVER);
  endtask

  task automatic test_cbz();
    check_instr("cbz_taken", OP_CBZ, 1'b1, 0);
    check_instr("cbz_not_taken", OP_CBZ, 1'b0, 0);
  endtask

  task automatic test_illegal();
    check_instr("illegal_zero", 11'd0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [10:0] ops[8];
    logic [10:0] op;
    int d;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, 11'd0};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == OP_CBZ) op[2:0] = 3'($urandom_range(0, 7));
      if (op == 11'd0) op = 11'($urandom_range(0, 2047));
      d = ($urandom_range(0, 9) == 0) ? NEVER :
          (($urandom_range(0, 5) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 4)));
      check_instr("random", op, 1'($urandom_range(0, 1)), d);
    end
  endtask

  task automatic test_reset_mid_access();
    int n7;
    logic found;
    n7 = 0; found = 1'b0;
    opcode = OP_STUR; zero = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      dmem_ready = 1'b0;
      #1;
      if (state_dbg == 4'd7) n7++;
      if (n7 == 2) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found || dmem_req !== 1'b1) begin errors++; $display("FAIL midreset_reach got req=%b exp 1", dmem_req); end
    reset = 1'b1;
    #1;
    checks++; if (all_outs() !== 13'd0) begin errors++; $display("FAIL midreset_outs got %b exp 0", all_outs()); end
    checks++; if (retired !== '0) begin errors++; $display("FAIL midreset_retired got %0d exp 0", retired); end
    @(posedge clk); #1;
    checks++; if (ir_en !== 1'b0) begin errors++; $display("FAIL midreset_ir_en got %b exp 0", ir_en); end
    @(negedge clk);
    reset = 1'b0;
    exp_retired = '0;
    #1;
    checks++; if (state_dbg !== 4'd0 || ir_en !== 1'b1) begin errors++; $display("FAIL release_state got %0d/%b exp 0/1", state_dbg, ir_en); end
    check_instr("after_reset_add", OP_ADD, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldur_delay();
    test_stur_timeout();
    test_cbz();
    test_illegal();
    test_random();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the LEGv8 subset datapath over several cycles. Supported instructions: ADD, SUB, AND, ORR, LDUR, STUR, CBZ.
- Decodes IR[31:21] and drives the register file, ALU, data-memory and PC enables for each instruction phase.
- Talks to data memory through a req/ready handshake, with a timeout that aborts a hung access.
- The immediate-extension unit and the ALU sit in the datapath. This block only steers them.

Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for dmem_ready before the access is aborted (must be ≥1).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  11  IR[31:21], the opcode of the instruction currently held in IR.
- zero  input  1  ALU zero flag. Valid in BRANCH.
- dmem_ready  input  1  data memory has completed the current access.
- ir_en  output  1  load IR from instruction memory at PC.
- pc_en  output  1  update PC at the end of this cycle.
- pc_src  output  1  PC source select: 0 = PC+4, 1 = PC+branch offset.
- reg2loc  output  1  register-read select: 1 = read Rt into read port 2 (STUR, CBZ), 0 = read Rm.
- alu_src  output  1  ALU B operand select: 1 = extended immediate, 0 = register.
- alu_op  output  2  00 = add (address calculation), 01 = pass B (CBZ), 10 = R-type funct decode.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  write-back source: 1 = memory data, 0 = ALU result.
- dmem_req  output  1  data-memory request, held high until accepted.
- dmem_we  output  1  1 = write, 0 = read. Qualified by dmem_req.
- illegal  output  1  one-cycle pulse: undecodable opcode.
- mem_err  output  1  one-cycle pulse: data-memory timeout.
- retired  output  CNT_W  count of completed instructions, including illegal and aborted ones.
- state_dbg  output  4  current state encoding, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, ADDR=4, MEM_RD=5, WB_LD=6, MEM_WR=7, BRANCH=8, ABORT=9.
- Reset:
  - State goes to FETCH, the timeout counter goes to 0 and retired goes to 0.
  - While reset is high, every control output is 0, including ir_en.
  - Reset asserted mid-access drops dmem_req immediately. No write completes.
- FETCH: ir_en=1. Next state is DECODE unconditionally.
- DECODE: reg2loc=1 if the opcode is STUR or CBZ. Next state is chosen from the opcode:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R.
  - LDUR 11111000010, STUR 11111000000 -> ADDR.
  - CBZ 10110100??? (low 3 bits don't care) -> BRANCH.
  - Any other opcode -> ABORT, with illegal=1 in the DECODE cycle.
- EXEC_R: alu_op=10, alu_src=0. Next state is WB_R.
- WB_R: reg_write=1, mem_to_reg=0, pc_en=1, pc_src=0. Next state is FETCH.
- ADDR: alu_op=00, alu_src=1, reg2loc held at its DECODE value. Clear the timeout counter. Next state is MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD and MEM_WR handshake:
  - Drive dmem_req=1, dmem_we=0 in MEM_RD and 1 in MEM_WR. Hold alu_op=00, alu_src=1.
  - If dmem_ready is seen in the same cycle, the access completes. From MEM_RD go to WB_LD. From MEM_WR assert pc_en=1, pc_src=0 and go to FETCH.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ready, pulse mem_err and go to ABORT.
  - dmem_req never drops while waiting. It is low in every other state.
  - dmem_ready outside MEM_RD and MEM_WR is ignored.
- WB_LD: reg_write=1, mem_to_reg=1, pc_en=1, pc_src=0. Next state is FETCH.
- BRANCH: alu_op=01, reg2loc=1, pc_en=1, pc_src=zero. Next state is FETCH.
- ABORT: pc_en=1, pc_src=0, so the faulting instruction is skipped. No reg_write. Next state is FETCH.
- retired increments by 1 on every cycle where pc_en=1 and wraps modulo 2^CNT_W.
- Latency in cycles, with ready on the first memory cycle:
  - R-type: 4.
  - LDUR: 5.
  - STUR: 4.
  - CBZ: 3.
  - Illegal: 3.
- Outputs are Moore-decoded from state, except dmem-dependent pc_en and mem_err in MEM states and illegal in DECODE. Any state encoding not listed goes to FETCH.

Test Plan:
- ADD opcode 10001011000 after reset release -> state sequence 0,1,2,3,0. reg_write=1 only in WB_R. retired goes 0->1.
- LDUR with dmem_ready delayed 3 cycles -> dmem_req high for exactly 4 cycles with dmem_we=0. WB_LD has reg_write=1, mem_to_reg=1. 8 cycles in total.
- STUR with ready never asserted, TIMEOUT=16 -> dmem_req high for 16 cycles, then mem_err pulse, ABORT, FETCH. reg_write is never 1. retired +1.
- CBZ opcode 10110100101 with zero=1, then again with zero=0 -> BRANCH has pc_src=1 then 0, pc_en=1 both times. 3 cycles each.
- Opcode 00000000000 -> illegal pulse in DECODE, ABORT with pc_en=1, then FETCH. No other enables.
- Reset asserted in the second MEM_WR wait cycle -> dmem_req drops asynchronously and all outputs are 0. After release, state=FETCH and retired=0.
